// File: rtl/enc_pkg.sv
// Shared width helpers and the default pipeline-slot record for the SECDED stream encoder.
package enc_pkg;

  // Default slot record, sized for the 32-bit / 3-mode configuration.
  typedef struct packed {
    logic        valid;
    logic [31:0] word;
    logic [1:0]  mode;
    logic        err;
  } enc_slot_t;

  // Codeword width n for mode m
  function automatic int unsigned cw_width(input int unsigned max_cw,
                                           input int unsigned num_modes,
                                           input int unsigned m);
    return max_cw >> (num_modes - 1 - m);
  endfunction

  // Hamming parity bit count r = log2(n)
  function automatic int unsigned par_width(input int unsigned max_cw,
                                            input int unsigned num_modes,
                                            input int unsigned m);
    return $clog2(cw_width(max_cw, num_modes, m));
  endfunction

  // Info width k = n - r - 1
  function automatic int unsigned info_width(input int unsigned max_cw,
                                             input int unsigned num_modes,
                                             input int unsigned m);
    return cw_width(max_cw, num_modes, m) - par_width(max_cw, num_modes, m) - 1;
  endfunction

  function automatic logic is_pow2(input int unsigned i);
    return (i != 0) && ((i & (i - 1)) == 0);
  endfunction

endpackage

// File: rtl/enc_pipe_slot.sv
// Single valid/ready register slot; the payload record carries its own valid flag.
module enc_pipe_slot
  import enc_pkg::*;
#(
  parameter type slot_t = enc_slot_t
) (
  input  logic  clk,
  input  logic  rst,
  input  slot_t d,
  output logic  ready,
  input  logic  down_ready,
  output slot_t q
);

  assign ready = !q.valid || down_ready;

  // Load a new beat when the slot is free or being drained; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ready) begin
      if (d.valid) begin
        q <= d;
      end else begin
        q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/enc_stream.sv
// Streaming multi-mode extended-Hamming (SECDED) encoder, two-stage valid/ready pipeline.
module enc_stream
  import enc_pkg::*;
#(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned NUM_MODES          = 3,
  parameter int unsigned MODE_W             = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [MODE_W-1:0]             work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [MODE_W-1:0]             out_mod,
  output logic                          out_err
);

  localparam int unsigned W       = MAX_CODEWORD_WIDTH;
  localparam int unsigned K_TOP   = info_width(W, NUM_MODES, NUM_MODES - 1);
  localparam logic [W-1:0] LSB_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              valid;
    logic [W-1:0]      word;
    logic [MODE_W-1:0] mode;
    logic              err;
  } slot_t;

  // Info-bit index that lands on Hamming position pos (pos is a non-power-of-two)
  function automatic int unsigned info_idx(input int unsigned pos);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned q = 3; q < pos; q++) begin
      if (!is_pow2(q)) cnt++;
    end
    return cnt;
  endfunction

  // Data positions below n covered by parity bit p_j
  function automatic logic [W-1:0] par_mask(input int unsigned n, input int unsigned j);
    logic [W-1:0] mask;
    mask = '0;
    for (int unsigned i = 3; i < n; i++) begin
      if (!is_pow2(i) && (((i >> j) & 32'd1) != 0)) mask = mask | (LSB_ONE << i);
    end
    return mask;
  endfunction

  slot_t s1_d, s1_q, s2_d, s2_q;
  logic  s1_ready, s2_ready;

  // AND-OR select chains across modes; an illegal mode hits nothing and yields zero.
  logic [NUM_MODES:0][W-1:0] word_acc;
  logic [NUM_MODES:0]        hit_acc;
  logic [NUM_MODES:0]        par_acc;

  assign word_acc[0] = '0;
  assign hit_acc[0]  = 1'b0;
  assign par_acc[0]  = 1'b0;

  for (genvar gm = 0; gm < NUM_MODES; gm++) begin : g_mode
    localparam int unsigned N = cw_width(W, NUM_MODES, gm);
    localparam int unsigned R = par_width(W, NUM_MODES, gm);

    logic [W-1:0] sc;
    logic [W-1:0] cw;
    logic         hit_in;
    logic         hit_s1;

    for (genvar i = 0; i < W; i++) begin : g_pos
      if (i > 0 && i < N && !is_pow2(i)) begin : g_info
        assign sc[i] = data_in[info_idx(i)];
      end else begin : g_fill
        assign sc[i] = 1'b0;
      end
    end

    // Insert each Hamming parity bit at its power-of-two position.
    always_comb begin
      cw = sc;
      for (int unsigned j = 0; j < R; j++) begin
        if (^(sc & par_mask(N, j))) cw = cw | (LSB_ONE << (1 << j));
      end
    end

    assign hit_in = (32'(work_mod) == gm);
    assign hit_s1 = (32'(s1_q.mode) == gm);

    assign word_acc[gm+1] = word_acc[gm] | (hit_in ? cw : '0);
    assign hit_acc[gm+1]  = hit_acc[gm] | hit_in;
    assign par_acc[gm+1]  = par_acc[gm] | (hit_s1 & (^s1_q.word[N-1:0]));
  end

  // S1 payload: scattered info plus Hamming parity, mode and illegal-mode flag.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.word  = word_acc[NUM_MODES];
    s1_d.mode  = work_mod;
    s1_d.err   = !hit_acc[NUM_MODES];
  end

  // S2 payload: S1 word with the overall even parity placed in bit 0.
  always_comb begin
    s2_d         = s1_q;
    s2_d.word[0] = par_acc[NUM_MODES];
  end

  enc_pipe_slot #(.slot_t(slot_t)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .d         (s1_d),
    .ready     (s1_ready),
    .down_ready(s2_ready),
    .q         (s1_q)
  );

  enc_pipe_slot #(.slot_t(slot_t)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .d         (s2_d),
    .ready     (s2_ready),
    .down_ready(out_ready),
    .q         (s2_q)
  );

  assign in_ready  = s1_ready && !rst;
  assign out_valid = s2_q.valid;
  assign data_out  = s2_q.word;
  assign out_mod   = s2_q.mode;
  assign out_err   = s2_q.err;

  // Info bits above the widest mode's k are ignored by design.
  logic unused_data;
  assign unused_data = ^data_in[W-1:K_TOP];

endmodule

// File: tb/tb_enc_stream.sv
// Self-checking bench for enc_stream: directed table, handshake corner cases, random traffic.
`timescale 1ns/1ps
module tb_enc_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [31:0] a_data_in, a_data_out;
  logic [1:0]  a_work_mod, a_out_mod;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [63:0] b_data_in, b_data_out;
  logic [1:0]  b_work_mod, b_out_mod;

  enc_stream #(.MAX_CODEWORD_WIDTH(32), .NUM_MODES(3)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .work_mod(a_work_mod),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .data_out(a_data_out), .out_mod(a_out_mod), .out_err(a_out_err)
  );

  enc_stream #(.MAX_CODEWORD_WIDTH(64), .NUM_MODES(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .work_mod(b_work_mod),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_data_out), .out_mod(b_out_mod), .out_err(b_out_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: place info bits, then set parity bits from the syndrome of the data positions.
  function automatic logic [63:0] ref_encode(input int unsigned maxw, input int unsigned nm,
                                             input int unsigned m, input logic [63:0] d);
    logic [63:0] cw;
    int unsigned n, syn, nb;
    cw = '0; syn = 0; nb = 0;
    if (m >= nm) return '0;
    n = maxw >> (nm - 1 - m);
    for (int unsigned pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw = cw | (((d >> nb) & 64'd1) << pos);
        nb++;
      end
    end
    for (int unsigned pos = 1; pos < n; pos++)
      if (((cw >> pos) & 64'd1) != 0) syn = syn ^ pos;
    for (int unsigned pos = 1; pos < n; pos = pos << 1)
      if ((syn & pos) != 0) cw = cw | (64'd1 << pos);
    cw = cw | 64'(^cw);
    return cw;
  endfunction

  function automatic int unsigned syndrome(input logic [63:0] w);
    int unsigned s;
    s = 0;
    for (int unsigned pos = 1; pos < 64; pos++)
      if (((w >> pos) & 64'd1) != 0) s = s ^ pos;
    return s;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mode;
    logic        err;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  int   a_times[$];

  logic        a_stalled = 1'b0;
  logic [31:0] a_hold_data;
  logic [1:0]  a_hold_mod;
  logic        a_hold_err;

  // Scoreboard for the 32/3 instance: order, content, and stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      a_q.delete();
      a_stalled = 1'b0;
    end else begin
      if (a_stalled) begin
        check("a_hold_valid", 64'(a_out_valid), 64'd1);
        check("a_hold_data", 64'(a_out_data_w()), 64'(a_hold_data));
        check("a_hold_mod", 64'(a_out_mod), 64'(a_hold_mod));
        check("a_hold_err", 64'(a_out_err), 64'(a_hold_err));
      end
      if (a_out_valid && a_out_ready) begin
        a_times.push_back(cyc);
        if (a_q.size() == 0) begin
          check("a_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = a_q.pop_front();
          check("a_data", 64'(a_data_out), e.data);
          check("a_mod", 64'(a_out_mod), 64'(e.mode));
          check("a_err", 64'(a_out_err), 64'(e.err));
        end
      end
      a_stalled   = a_out_valid && !a_out_ready;
      a_hold_data = a_data_out;
      a_hold_mod  = a_out_mod;
      a_hold_err  = a_out_err;
      if (a_in_valid && a_in_ready) begin
        e.data = ref_encode(32, 3, a_work_mod, {32'd0, a_data_in});
        e.mode = a_work_mod;
        e.err  = (a_work_mod >= 2'd3);
        a_q.push_back(e);
      end
    end
  end

  function automatic logic [31:0] a_out_data_w();
    return a_data_out;
  endfunction

  // Scoreboard for the 64/4 instance plus codeword-property checks.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      b_q.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        check("b_syndrome", 64'(syndrome(b_data_out)), 64'd0);
        check("b_overall_parity", 64'(^b_data_out), 64'd0);
        if (b_q.size() == 0) begin
          check("b_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = b_q.pop_front();
          check("b_data", b_data_out, e.data);
          check("b_mod", 64'(b_out_mod), 64'(e.mode));
          check("b_err", 64'(b_out_err), 64'(e.err));
        end
      end
      if (b_in_valid && b_in_ready) begin
        e.data = ref_encode(64, 4, b_work_mod, b_data_in);
        e.mode = b_work_mod;
        e.err  = 1'b0;
        b_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vec[8];

  initial begin
    int lat;
    int acc;
    int seen;
    logic got;

    vec[0] = '{2'd0, 32'h0000000B, 32'h000000AA, 1'b0};
    vec[1] = '{2'd1, 32'h000007FF, 32'h0000FFFF, 1'b0};
    vec[2] = '{2'd2, 32'h03FFFFFF, 32'hFFFFFFFF, 1'b0};
    vec[3] = '{2'd0, 32'hFFFFFFF0, 32'h00000000, 1'b0};
    vec[4] = '{2'd0, 32'h00000001, 32'h0000000F, 1'b0};
    vec[5] = '{2'd2, 32'h02000000, 32'h80010116, 1'b0};
    vec[6] = '{2'd3, 32'h0000000B, 32'h00000000, 1'b1};
    vec[7] = '{2'd1, 32'h00000001, 32'h0000000F, 1'b0};

    rst = 1'b1;
    a_in_valid = 1'b0; a_data_in = '0; a_work_mod = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_data_in = '0; b_work_mod = '0; b_out_ready = 1'b0;
    repeat (3) tick();

    @(negedge clk);
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_data_out", 64'(a_data_out), 64'd0);
    check("rst_out_mod", 64'(a_out_mod), 64'd0);
    check("rst_out_err", 64'(a_out_err), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(a_in_ready), 64'd1);
    tick();

    // Table: single beats, latency and exact codewords.
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_work_mod = vec[i].mode;
      a_data_in  = vec[i].data;
      tick();
      a_in_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        if (a_out_valid) got = 1'b1;
        else begin
          tick();
          lat++;
        end
      end
      check("vec_arrived", 64'(got), 64'd1);
      check("vec_latency", 64'(lat), 64'd2);
      check("vec_data", 64'(a_data_out), 64'(vec[i].exp_data));
      check("vec_mod", 64'(a_out_mod), 64'(vec[i].mode));
      check("vec_err", 64'(a_out_err), 64'(vec[i].exp_err));
      tick();
    end

    // Back-to-back beats cycling through all modes.
    a_times.delete();
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1;
      a_work_mod = 2'(i % 3);
      a_data_in  = $urandom;
      tick();
    end
    a_in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("b2b_count", 64'(a_times.size()), 64'd6);
    if (a_times.size() == 6)
      for (int i = 1; i < 6; i++) check("b2b_consecutive", 64'(a_times[i]), 64'(a_times[0] + i));
    tick();

    // Fill with downstream stalled, then release while still feeding.
    a_out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_work_mod = 2'($urandom_range(0, 2));
      a_data_in  = $urandom;
      @(negedge clk);
      if (a_in_ready) acc++;
      tick();
    end
    @(negedge clk);
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_in_ready", 64'(a_in_ready), 64'd0);
    tick();
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_work_mod = 2'($urandom_range(0, 2));
      a_data_in  = $urandom;
      @(negedge clk);
      check("flow_in_ready", 64'(a_in_ready), 64'd1);
      tick();
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 10 && a_q.size() != 0; i++) tick();
    @(negedge clk);
    check("flow_drained", 64'(a_q.size()), 64'd0);
    tick();

    // Reset with two beats in flight and the output stalled.
    a_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1;
      a_work_mod = 2'(i);
      a_data_in  = $urandom;
      tick();
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(a_out_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(a_out_valid), 64'd0);
    check("post_rst_data", 64'(a_data_out), 64'd0);
    check("post_rst_mod", 64'(a_out_mod), 64'd0);
    check("post_rst_err", 64'(a_out_err), 64'd0);
    check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    check("post_rst_no_output", 64'(seen), 64'd0);
    tick();

    // Random traffic on both instances, including illegal modes on the 3-mode one.
    for (int c = 0; c < 800; c++) begin
      a_in_valid  = ($urandom % 4) != 0;
      a_data_in   = $urandom;
      a_work_mod  = 2'($urandom % 4);
      a_out_ready = ($urandom % 4) != 0;
      b_in_valid  = ($urandom % 4) != 0;
      b_data_in   = {$urandom, $urandom};
      b_work_mod  = 2'($urandom % 4);
      b_out_ready = ($urandom % 4) != 0;
      tick();
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 20 && (a_q.size() != 0 || b_q.size() != 0); i++) tick();
    @(negedge clk);
    check("rand_a_drained", 64'(a_q.size()), 64'd0);
    check("rand_b_drained", 64'(b_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
